// File: rtl/draw_pkg.sv
// Shared types and screen defaults for the shape renderer control path.
package draw_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, DRAW, DONE} state_t;

  typedef struct packed {
    logic [2:0] colour;
    logic [7:0] cx;
    logic [6:0] cy;
    logic [7:0] diam;
  } shape_params_t;

endpackage

// File: rtl/draw_sequencer_fill_scan.sv
// Column-major raster counter: y sweeps fastest, x advances when y wraps.
module fill_scan
  import draw_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  localparam int XW = $clog2(SCREEN_W),
  localparam int YW = $clog2(SCREEN_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          first,
  output logic          last,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y
);

  localparam logic [XW-1:0] XMAX = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(SCREEN_H - 1);

  assign last = (x == XMAX) && (y == YMAX);

  // first parks the scan at the origin so every fill starts from (0,0)
  always_ff @(posedge clk) begin
    if (rst || first) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (y == YMAX) begin
        y <= '0;
        x <= last ? '0 : x + 1'b1;
      end else begin
        y <= y + 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// Sequences clear-then-draw for the reuleaux drawer and muxes both pixel
// streams onto the single VGA plot port, clipping off-screen drawer pixels.
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int         SCREEN_W    = SCREEN_W_DEF,
  parameter int         SCREEN_H    = SCREEN_H_DEF,
  parameter logic [2:0] BG_COLOUR   = 3'b000,
  parameter bit         AUTO_REDRAW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [2:0] colour,
  input  logic [7:0] centre_x,
  input  logic [6:0] centre_y,
  input  logic [7:0] diameter,
  output logic       shape_start,
  output logic [2:0] shape_colour,
  output logic [7:0] shape_cx,
  output logic [6:0] shape_cy,
  output logic [7:0] shape_diam,
  input  logic       shape_done,
  input  logic [7:0] shape_x,
  input  logic [6:0] shape_y,
  input  logic [2:0] shape_pcol,
  input  logic       shape_plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  localparam int XW = $clog2(SCREEN_W);
  localparam int YW = $clog2(SCREEN_H);
  localparam logic [8:0] X_LIM = 9'(SCREEN_W);
  localparam logic [7:0] Y_LIM = 8'(SCREEN_H);

  state_t        state;
  shape_params_t params_q;
  shape_params_t req;
  logic          params_changed;
  logic          on_screen;
  logic          scan_last;
  logic [XW-1:0] scan_x;
  logic [YW-1:0] scan_y;

  assign req            = {colour, centre_x, centre_y, diameter};
  assign params_changed = (req != params_q);
  assign on_screen      = ({1'b0, shape_x} < X_LIM) && ({1'b0, shape_y} < Y_LIM);

  assign shape_colour = params_q.colour;
  assign shape_cx     = params_q.cx;
  assign shape_cy     = params_q.cy;
  assign shape_diam   = params_q.diam;

  fill_scan #(
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H)
  ) u_scan (
    .clk  (clk),
    .rst  (rst),
    .en   (state == CLEAR),
    .first(state != CLEAR),
    .last (scan_last),
    .x    (scan_x),
    .y    (scan_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      params_q    <= '0;
      shape_start <= 1'b0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_colour  <= '0;
      vga_plot    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          vga_plot <= 1'b0;
          if (go) begin
            params_q <= req;
            state    <= CLEAR;
            busy     <= 1'b1;
          end
        end
        CLEAR: begin
          vga_x      <= 8'(scan_x);
          vga_y      <= 7'(scan_y);
          vga_colour <= BG_COLOUR;
          vga_plot   <= 1'b1;
          if (scan_last) state <= LAUNCH;
        end
        LAUNCH: begin
          vga_plot    <= 1'b0;
          shape_start <= 1'b1;
          state       <= DRAW;
        end
        // drawer pixels pass through one register; the done-cycle pixel still lands
        DRAW: begin
          vga_x      <= shape_x;
          vga_y      <= shape_y;
          vga_colour <= shape_pcol;
          vga_plot   <= shape_plot && on_screen;
          if (shape_done) begin
            shape_start <= 1'b0;
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
          end
        end
        DONE: begin
          vga_plot <= 1'b0;
          if (AUTO_REDRAW && params_changed) begin
            params_q <= req;
            state    <= CLEAR;
            busy     <= 1'b1;
            done     <= 1'b0;
          end else if (!go) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_sequencer.sv
// Scoreboarded bench: clear raster, clipped drawer pass-through, redraw and reset corners.
module tb_draw_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, go;
  logic [2:0] colour;
  logic [7:0] centre_x;
  logic [6:0] centre_y;
  logic [7:0] diameter;
  logic       shape_done, shape_plot;
  logic [7:0] shape_x;
  logic [6:0] shape_y;
  logic [2:0] shape_pcol;

  logic       shape_start_a, shape_start_b;
  logic [2:0] shape_colour_a, shape_colour_b;
  logic [7:0] shape_cx_a, shape_cx_b;
  logic [6:0] shape_cy_a, shape_cy_b;
  logic [7:0] shape_diam_a, shape_diam_b;
  logic [7:0] vga_x_a, vga_x_b;
  logic [6:0] vga_y_a, vga_y_b;
  logic [2:0] vga_colour_a, vga_colour_b;
  logic       vga_plot_a, vga_plot_b;
  logic       busy_a, busy_b, done_a, done_b;

  draw_sequencer #(.AUTO_REDRAW(1'b1)) dut_a (
    .clk(clk), .rst(rst), .go(go), .colour(colour), .centre_x(centre_x),
    .centre_y(centre_y), .diameter(diameter), .shape_start(shape_start_a),
    .shape_colour(shape_colour_a), .shape_cx(shape_cx_a), .shape_cy(shape_cy_a),
    .shape_diam(shape_diam_a), .shape_done(shape_done), .shape_x(shape_x),
    .shape_y(shape_y), .shape_pcol(shape_pcol), .shape_plot(shape_plot),
    .vga_x(vga_x_a), .vga_y(vga_y_a), .vga_colour(vga_colour_a),
    .vga_plot(vga_plot_a), .busy(busy_a), .done(done_a)
  );

  draw_sequencer #(.AUTO_REDRAW(1'b0)) dut_b (
    .clk(clk), .rst(rst), .go(go), .colour(colour), .centre_x(centre_x),
    .centre_y(centre_y), .diameter(diameter), .shape_start(shape_start_b),
    .shape_colour(shape_colour_b), .shape_cx(shape_cx_b), .shape_cy(shape_cy_b),
    .shape_diam(shape_diam_b), .shape_done(shape_done), .shape_x(shape_x),
    .shape_y(shape_y), .shape_pcol(shape_pcol), .shape_plot(shape_plot),
    .vga_x(vga_x_b), .vga_y(vga_y_b), .vga_colour(vga_colour_b),
    .vga_plot(vga_plot_b), .busy(busy_b), .done(done_b)
  );

  typedef struct {
    int x;
    int y;
    int col;
    int cyc;
  } pix_t;

  typedef struct {
    int x;
    int y;
    int pcol;
    bit plot;
    bit sdone;
    bit fwd;
    bit exp_start;
    bit exp_done;
    bit exp_busy;
  } row_t;

  pix_t sbq[$];
  row_t rows[5];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: advance, sample dut_a's VGA port against the scoreboard, leave inputs free to drive.
  task automatic tick();
    pix_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (vga_plot_a) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL vga_unexpected got (%0d,%0d,c%0d) expected no plot (cycle %0d)",
                 vga_x_a, vga_y_a, vga_colour_a, cyc);
      end else begin
        e = sbq.pop_front();
        if (int'(vga_x_a) != e.x || int'(vga_y_a) != e.y ||
            int'(vga_colour_a) != e.col || cyc != e.cyc) begin
          errors++;
          $display("FAIL vga_pixel got (%0d,%0d,c%0d)@%0d expected (%0d,%0d,c%0d)@%0d",
                   vga_x_a, vga_y_a, vga_colour_a, cyc, e.x, e.y, e.col, e.cyc);
        end
      end
    end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      checks++;
      errors++;
      e = sbq.pop_front();
      $display("FAIL vga_missing got no plot expected (%0d,%0d,c%0d)@%0d",
               e.x, e.y, e.col, e.cyc);
    end
    #1;
  endtask

  task automatic push_clear(input int base);
    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 120; y++)
        sbq.push_back('{x, y, 0, base + x * 120 + y});
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20000 && !ok; n++) begin
      tick();
      if (shape_start_a) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL start_timeout got shape_start=0 expected rise within 20000 cycles");
    end
  endtask

  initial begin
    bit ok;
    int c0, c1, c2;

    rows[0] = '{10, 20, 2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    rows[1] = '{200, 5, 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    rows[2] = '{30, 119, 6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    rows[3] = '{30, 120, 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    rows[4] = '{5, 5, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; go = 1'b0; colour = '0; centre_x = '0; centre_y = '0; diameter = '0;
    shape_done = 1'b0; shape_plot = 1'b0; shape_x = '0; shape_y = '0; shape_pcol = '0;
    tick();
    tick();
    chk("rst_plot", vga_plot_a, 0);
    chk("rst_start", shape_start_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_diam", shape_diam_a, 0);
    chk("rst_vga_x", vga_x_a, 0);

    // First request: full clear, then launch
    rst = 1'b0; colour = 3'b010; centre_x = 8'd80; centre_y = 7'd60; diameter = 8'd40; go = 1'b1;
    c0 = cyc;
    push_clear(c0 + 2);
    tick();
    chk("latch_busy", busy_a, 1);
    chk("latch_cx", shape_cx_a, 80);
    chk("latch_cy", shape_cy_a, 60);
    chk("latch_diam", shape_diam_a, 40);
    chk("latch_colour", shape_colour_a, 2);
    wait_start(ok);
    chk("start_cycle", cyc, c0 + 2 + 19200);
    chk("clear_left", sbq.size(), 0);
    chk("launch_noplot", vga_plot_a, 0);
    chk("b_start", shape_start_b, 1);

    // Stub drawer stream, clipped and forwarded one cycle later
    for (int i = 0; i < 5; i++) begin
      shape_x = 8'(rows[i].x); shape_y = 7'(rows[i].y); shape_pcol = 3'(rows[i].pcol);
      shape_plot = rows[i].plot; shape_done = rows[i].sdone;
      if (rows[i].fwd) sbq.push_back('{rows[i].x, rows[i].y, rows[i].pcol, cyc + 1});
      tick();
      chk($sformatf("row%0d_start", i), shape_start_a, rows[i].exp_start);
      chk($sformatf("row%0d_done", i), done_a, rows[i].exp_done);
      chk($sformatf("row%0d_busy", i), busy_a, rows[i].exp_busy);
    end
    shape_plot = 1'b0; shape_done = 1'b0;
    repeat (3) tick();
    chk("done_hold", done_a, 1);
    shape_x = 8'd1; shape_y = 7'd1; shape_plot = 1'b1;
    tick();
    shape_plot = 1'b0;
    tick();
    chk("draw_left", sbq.size(), 0);
    chk("done_after_stray", done_a, 1);

    // Parameter change in DONE: auto redraw versus hold
    diameter = 8'd42;
    c1 = cyc;
    push_clear(c1 + 2);
    tick();
    chk("redraw_busy", busy_a, 1);
    chk("redraw_done", done_a, 0);
    chk("redraw_diam", shape_diam_a, 42);
    chk("b_stay_done", done_b, 1);
    chk("b_diam", shape_diam_b, 40);
    repeat (3) tick();
    chk("b_still_done", done_b, 1);

    // Reset on clear pixel 5000
    while (cyc < c1 + 2 + 5000) tick();
    rst = 1'b1; go = 1'b0;
    sbq.delete();
    tick();
    chk("mid_rst_plot", vga_plot_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_start", shape_start_a, 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy_a, 0);
    chk("idle_done", done_a, 0);

    // Restart from origin; centre_x change mid-clear must not leak
    go = 1'b1;
    c2 = cyc;
    push_clear(c2 + 2);
    tick();
    chk("restart_cx", shape_cx_a, 80);
    repeat (100) tick();
    centre_x = 8'd10;
    wait_start(ok);
    chk("restart_start_cycle", cyc, c2 + 2 + 19200);
    chk("clear_cx", shape_cx_a, 80);
    repeat (3) tick();
    chk("draw_cx", shape_cx_a, 80);
    shape_done = 1'b1;
    tick();
    shape_done = 1'b0;
    chk("done2_done", done_a, 1);
    chk("done2_cx", shape_cx_a, 80);
    tick();
    chk("relatch_busy", busy_a, 1);
    chk("relatch_cx", shape_cx_a, 10);
    chk("b_cx_hold", shape_cx_b, 80);
    chk("b_done_hold", done_b, 1);
    rst = 1'b1; go = 1'b0;
    sbq.delete();
    tick();
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_sequencer.md
Name: draw_sequencer

Overview:
- Control stage directly upstream of the reuleaux drawer and the vga_adapter in the 160x120 shape renderer.
- On a request it latches the shape parameters, clears the framebuffer to a background colour, and holds start to the drawer until the drawer reports done.
- Throughout, it muxes the clear stream and the drawer's pixel stream onto the single VGA plot port, dropping drawer pixels that fall off-screen.
- Optionally re-triggers itself when the switch-driven parameters change.

Parameters:
SCREEN_W, 160, horizontal resolution; clear x range 0..SCREEN_W-1
SCREEN_H, 120, vertical resolution; clear y range 0..SCREEN_H-1
BG_COLOUR, 3'b000, colour written during clear
AUTO_REDRAW, 1, 1 = parameter change while in DONE starts a new cycle

Ports:
clk  input  1  system clock (CLOCK_50 at top level)
rst  input  1  synchronous active-high reset
go  input  1  level request; sampled in IDLE
colour  input  3  shape colour request
centre_x  input  8  shape centre x request
centre_y  input  7  shape centre y request
diameter  input  8  shape diameter request
shape_start  output  1  start to the drawer
shape_colour  output  3  latched colour to the drawer
shape_cx  output  8  latched centre x to the drawer
shape_cy  output  7  latched centre y to the drawer
shape_diam  output  8  latched diameter to the drawer
shape_done  input  1  done from the drawer
shape_x  input  8  drawer pixel x
shape_y  input  7  drawer pixel y
shape_pcol  input  3  drawer pixel colour
shape_plot  input  1  drawer pixel strobe
vga_x  output  8  to the adapter
vga_y  output  7  to the adapter
vga_colour  output  3  to the adapter
vga_plot  output  1  to the adapter
busy  output  1  high in CLEAR, LAUNCH and DRAW
done  output  1  high in DONE

Behaviour:
- The clock is clk. Reset is rst: synchronous, active-high.
- Reset values:
  - State is IDLE.
  - All outputs and the latched parameters are 0.
  - The clear counters are 0.
- States:
  - IDLE -> CLEAR when go=1. On the transition, latch colour, centre_x, centre_y and diameter.
  - CLEAR: x-outer, y-inner scan from (0,0) to (SCREEN_W-1, SCREEN_H-1). One pixel per cycle with vga_colour=BG_COLOUR and vga_plot=1. After the last pixel (159,119) is emitted, go to LAUNCH. A full clear is exactly 19200 plot cycles.
  - LAUNCH: one cycle with vga_plot=0. Assert shape_start. Go to DRAW.
  - DRAW:
    - shape_start stays high.
    - Registered pass-through: shape_x, shape_y, shape_pcol and shape_plot appear on vga_* one cycle later.
    - Clip: vga_plot is 1 only if shape_plot=1, shape_x<SCREEN_W and shape_y<SCREEN_H.
    - When shape_done=1 is sampled, deassert shape_start on the next edge and go to DONE.
  - DONE:
    - done=1, vga_plot=0.
    - If go=0, go to IDLE.
    - If AUTO_REDRAW=1 and any of colour, centre_x, centre_y, diameter differs from the latched value, re-latch and go to CLEAR.
    - If both conditions hold, the redraw wins.
- shape_cx, shape_cy, shape_diam and shape_colour are stable from the latch until the next latch. Input changes during CLEAR or DRAW are ignored.
- go is ignored outside IDLE and DONE. go=0 mid-operation does not abort the cycle.
- A drawer plot in DRAW on the same cycle as shape_done is still forwarded.
- Drawer plots outside DRAW are ignored.
- Reset asserted mid-CLEAR or mid-DRAW:
  - Next cycle is IDLE.
  - vga_plot=0 and shape_start=0.
  - Counters are cleared; no partial resume.
- Counters are sized $clog2(SCREEN_W) and $clog2(SCREEN_H) bits. The clear x counter wraps only via the state change; no modular overflow is relied on.

Decomposition:
- Package draw_pkg holds:
  - the state enum (IDLE, CLEAR, LAUNCH, DRAW, DONE);
  - the SCREEN_W and SCREEN_H defaults;
  - a packed shape_params_t struct {colour, cx, cy, diam}, used for latch and compare.
- One sub-module, fill_scan: the x/y raster counter. It has en, first, last, x, y and is reusable by the fillscreen task.

Test Plan:
- rst=1 for 2 cycles, then go=1 with diameter=40, centre (80,60), colour=3'b010.
  - Exactly 19200 vga_plot pulses with colour 000 in CLEAR.
  - First pixel (0,0); pixel 120 is (1,0); last pixel (159,119).
  - Then shape_start rises one cycle after the last clear pixel.
- With a stub drawer, emit plots (10,20), (200,5), (30,119), (30,120) in DRAW.
  - Only (10,20) and (30,119) appear on vga_*, each one cycle later.
- Stub asserts shape_done together with a plot at (5,5).
  - (5,5) is forwarded.
  - shape_start falls next cycle; done=1 and busy=0.
- In DONE with go held, change diameter 40 -> 42.
  - Next cycle is CLEAR with shape_diam=42.
  - Repeat with AUTO_REDRAW=0: the block stays in DONE.
- Pulse rst at clear pixel 5000.
  - Next cycle is IDLE with vga_plot=0.
  - The following go restarts the clear at (0,0).
- In CLEAR, change centre_x 80 -> 10.
  - shape_cx stays 80 through DRAW.
